mixed_param_requester: RTL and testbench
========================================

# mixed_param_requester

Initiator-side driver for the mixed-parameter target port (`clk`/`reset`/`data_in`/`addr`/`enable` → `ready`/`normal_data_out`/`extended_data_out`/`full_addr`/`status`). It accepts host commands through a valid/ready interface and buffers them in a small FIFO. It issues one target transaction at a time, holding `enable` until `ready`, and returns the captured target outputs as a valid/ready response with timeout protection. It sits between a host/bus adapter and one target instance, in the same wrapper level as the target.

## Interface
- `DATA_WIDTH`, 16: target data width; extended data is 3×DATA_WIDTH.
- `ADDR_WIDTH`, 12: target address width; full address is 2×ADDR_WIDTH.
- `FIFO_DEPTH`, 4: command FIFO entries; a power of two, ≥2.
- `TIMEOUT`, 256: max cycles `enable` is held waiting for `ready`; ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_addr`  in  ADDR_WIDTH  command address.
- `cmd_data`  in  DATA_WIDTH  command data.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  host accepts response.
- `rsp_data`  out  DATA_WIDTH  captured `normal_data_out`.
- `rsp_ext`  out  3×DATA_WIDTH  captured `extended_data_out`.
- `rsp_full_addr`  out  2×ADDR_WIDTH  captured `full_addr`.
- `rsp_status`  out  4  captured `status`.
- `rsp_timeout`  out  1  transaction aborted by timeout.
- `tgt_enable`  out  1  drives target `enable`.
- `tgt_addr`  out  ADDR_WIDTH  drives target `addr`.
- `tgt_data`  out  DATA_WIDTH  drives target `data_in`.
- `tgt_ready`, `tgt_normal_data`, `tgt_ext_data`, `tgt_full_addr`, `tgt_status`  in  1/DATA_WIDTH/3×DATA_WIDTH/2×ADDR_WIDTH/4  target outputs.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- **Host push.** A command is pushed when `cmd_valid && cmd_ready`.
- **FSM states: IDLE, ISSUE, RESP.**
  - IDLE: if FIFO non-empty, pop the head into `tgt_addr`/`tgt_data`, clear the wait counter, go to ISSUE.
  - ISSUE: `tgt_enable`=1, with `tgt_addr`/`tgt_data` held stable.
    - If `tgt_ready`=1, register all target outputs into the `rsp_*` fields, set `rsp_timeout`=0, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without `ready`, zero the `rsp_*` fields, set `rsp_timeout`=1 and `rsp_status`=4'hF, go to RESP.
  - RESP: `rsp_valid`=1 with the `rsp_*` fields stable. On `rsp_ready` go to IDLE.
- **Transfer definition.** A target transfer is `tgt_enable && tgt_ready` in the same cycle. The target outputs are sampled in that cycle.
- **Simultaneous push and pop** in one cycle is legal when the FIFO is full: the pop frees a slot, but `cmd_ready` is still computed from registered count and is not combinationally relieved.
- **Ordering.** Responses are returned strictly in command order; one transaction is outstanding at most.
- **Counter width** is $clog2(TIMEOUT); the counter saturates and does not wrap.

## Timing
- **Reset values:** all outputs 0 (`cmd_ready`=0 during reset; it goes to 1 the cycle after reset deasserts), FIFO empty, FSM IDLE.
- **Reset mid-operation** aborts the transaction: `tgt_enable` is 0 the cycle after reset is sampled, and no response is produced.
- **Latency with `tgt_ready` tied high:** command pushed at edge N → `tgt_enable` high in cycle N+1 → `rsp_valid` high in cycle N+2. Back-to-back throughput is one command per 3 cycles (IDLE→ISSUE→RESP) when `rsp_ready` is held high.
- **Timeout:** `rsp_valid` with `rsp_timeout` rises exactly TIMEOUT cycles after `tgt_enable` rose, if `ready` never came.
- **`ready` in the final wait cycle** counts as success, not timeout.
- **`rsp_valid` holds** until accepted; `rsp_*` fields do not change while valid.

## Structure
- **Shared package `mixed_param_pkg`:** default widths, `STATUS_TIMEOUT` = 4'hF, FSM state enum `req_state_t`, and a packed command struct `{addr, data}`.
- **Sub-module `mixed_param_cmd_fifo`:** synchronous FIFO with registered count, `full`/`empty`, width ADDR_WIDTH+DATA_WIDTH, depth FIFO_DEPTH. The top level holds the FSM, timeout counter and response registers.

## Test plan
- **Single command:** `tgt_ready`=1, push addr=0x123, data=0xBEEF; target returns normal=0x1234, ext=0xAAAA_BBBB_CCCC, full_addr=0x00_0123, status=0x1 → one response with exactly those values, `rsp_timeout`=0, `rsp_valid` 2 cycles after the push.
- **Wait states:** `tgt_ready` low for 5 cycles after `enable` → `enable` held 6 cycles with addr/data stable; response arrives the cycle after `ready`.
- **Timeout:** TIMEOUT=8, `ready` stuck low → `rsp_timeout`=1, `rsp_status`=0xF, data fields 0, exactly 8 cycles after `enable` rose; the next queued command then issues normally.
- **FIFO full/backpressure:** `rsp_ready`=0, push 6 commands → `cmd_ready` drops after 4 are buffered plus 1 in flight; releasing `rsp_ready` returns all 5 accepted commands in order with matching addresses.
- **Reset mid-ISSUE:** assert `reset` while `enable`=1 → `enable`, `rsp_valid` and `busy` are 0 the next cycle; the FIFO is empty and no stale response appears afterwards.

Source files
------------

// File: rtl/mixed_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mixed_param_pkg                                          |
// | Brief   : Shared widths, status codes and types for the requester. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mixed_param_pkg;

    localparam int c_DEF_DATA_WIDTH = 16;
    localparam int c_DEF_ADDR_WIDTH = 12;
    localparam int c_DEF_FIFO_DEPTH = 4;
    localparam int c_DEF_TIMEOUT    = 256;

    localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_ISSUE = 2'd1,
        REQ_RESP  = 2'd2
    } req_state_t;

    typedef struct packed {
        logic [c_DEF_ADDR_WIDTH-1:0] addr;
        logic [c_DEF_DATA_WIDTH-1:0] data;
    } req_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mixed_param_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mixed_param_cmd_fifo                                     |
// | Brief   : Synchronous command FIFO with registered occupancy count. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mixed_param_cmd_fifo
    import mixed_param_pkg::*;
#(
    parameter int WIDTH = c_DEF_ADDR_WIDTH + c_DEF_DATA_WIDTH,
    parameter int DEPTH = c_DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mixed_param_requester.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mixed_param_requester                                    |
// | Brief   : Buffers host commands and drives one target transaction  |
// |           at a time, returning captured outputs with a timeout.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mixed_param_requester
    import mixed_param_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = c_DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [3*DATA_WIDTH-1:0] rsp_ext,
    output logic [2*ADDR_WIDTH-1:0] rsp_full_addr,
    output logic [3:0]              rsp_status,
    output logic                    rsp_timeout,
    output logic                    tgt_enable,
    output logic [ADDR_WIDTH-1:0]   tgt_addr,
    output logic [DATA_WIDTH-1:0]   tgt_data,
    input  logic                    tgt_ready,
    input  logic [DATA_WIDTH-1:0]   tgt_normal_data,
    input  logic [3*DATA_WIDTH-1:0] tgt_ext_data,
    input  logic [2*ADDR_WIDTH-1:0] tgt_full_addr,
    input  logic [3:0]              tgt_status,
    output logic                    busy
);

    localparam int         c_CNT_W    = $clog2(TIMEOUT);
    localparam int         c_CMD_W    = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0] c_ST_IDLE  = REQ_IDLE;
    localparam logic [1:0] c_ST_ISSUE = REQ_ISSUE;
    localparam logic [1:0] c_ST_RESP  = REQ_RESP;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_alive;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_CMD_W-1:0] w_head;

    // cmd_ready stays low through reset and for the cycle in which it is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    assign cmd_ready  = r_alive & ~w_full;
    assign w_push     = cmd_valid & cmd_ready;
    assign w_pop      = (r_state == c_ST_IDLE) & ~w_empty;
    assign tgt_enable = (r_state == c_ST_ISSUE);
    assign rsp_valid  = (r_state == c_ST_RESP);
    assign busy       = (r_state != c_ST_IDLE) | ~w_empty;

    mixed_param_cmd_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data ({cmd_addr, cmd_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_wait_cnt    <= '0;
            tgt_addr      <= '0;
            tgt_data      <= '0;
            rsp_data      <= '0;
            rsp_ext       <= '0;
            rsp_full_addr <= '0;
            rsp_status    <= '0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        {tgt_addr, tgt_data} <= w_head;
                        r_wait_cnt           <= '0;
                        r_state              <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    // ready is checked first so it wins even in the last wait cycle.
                    if (tgt_ready) begin
                        rsp_data      <= tgt_normal_data;
                        rsp_ext       <= tgt_ext_data;
                        rsp_full_addr <= tgt_full_addr;
                        rsp_status    <= tgt_status;
                        rsp_timeout   <= 1'b0;
                        r_state       <= c_ST_RESP;
                    end else if (r_wait_cnt >= c_CNT_W'(TIMEOUT - 1)) begin
                        rsp_data      <= '0;
                        rsp_ext       <= '0;
                        rsp_full_addr <= '0;
                        rsp_status    <= STATUS_TIMEOUT;
                        rsp_timeout   <= 1'b1;
                        r_state       <= c_ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixed_param_requester.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_mixed_param_requester                                 |
// | Brief   : Directed and randomized self-checking bench.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mixed_param_requester;

    localparam int c_DW = 16;
    localparam int c_AW = 12;
    localparam int c_TO = 8;

    typedef struct packed {
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [c_DW-1:0]   d;
        logic [3*c_DW-1:0] e;
        logic [2*c_AW-1:0] fa;
        logic [3:0]        st;
        logic              to;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready;
    logic [c_AW-1:0]   cmd_addr;
    logic [c_DW-1:0]   cmd_data;
    logic              rsp_valid, rsp_ready;
    logic [c_DW-1:0]   rsp_data;
    logic [3*c_DW-1:0] rsp_ext;
    logic [2*c_AW-1:0] rsp_full_addr;
    logic [3:0]        rsp_status;
    logic              rsp_timeout;
    logic              tgt_enable;
    logic [c_AW-1:0]   tgt_addr;
    logic [c_DW-1:0]   tgt_data;
    logic              tgt_ready;
    logic [c_DW-1:0]   tgt_normal_data;
    logic [3*c_DW-1:0] tgt_ext_data;
    logic [2*c_AW-1:0] tgt_full_addr;
    logic [3:0]        tgt_status;
    logic              busy;

    // Target model: either fixed values from the stimulus, or an echo of the request.
    logic              echo;
    logic [c_DW-1:0]   man_normal;
    logic [3*c_DW-1:0] man_ext;
    logic [2*c_AW-1:0] man_full;
    logic [3:0]        man_status;

    always_comb begin
        if (echo) begin
            tgt_normal_data = tgt_data ^ 16'h5A5A;
            tgt_ext_data    = {tgt_data, ~tgt_data, tgt_data};
            tgt_full_addr   = {tgt_addr, ~tgt_addr};
            tgt_status      = tgt_addr[3:0];
        end else begin
            tgt_normal_data = man_normal;
            tgt_ext_data    = man_ext;
            tgt_full_addr   = man_full;
            tgt_status      = man_status;
        end
    end

    always #5 clk = ~clk;

    mixed_param_requester #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (c_TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_ext         (rsp_ext),
        .rsp_full_addr   (rsp_full_addr),
        .rsp_status      (rsp_status),
        .rsp_timeout     (rsp_timeout),
        .tgt_enable      (tgt_enable),
        .tgt_addr        (tgt_addr),
        .tgt_data        (tgt_data),
        .tgt_ready       (tgt_ready),
        .tgt_normal_data (tgt_normal_data),
        .tgt_ext_data    (tgt_ext_data),
        .tgt_full_addr   (tgt_full_addr),
        .tgt_status      (tgt_status),
        .busy            (busy)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    cmd_t cmd_q[$];
    rsp_t exp_q[$];
    cmd_t cur;
    int   en_cnt;
    int   outstanding;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle; the model tracks accepted commands and predicted responses.
    task automatic rand_cycle(input bit offer);
        rsp_t r;
        cmd_valid  = offer && ($urandom_range(0, 2) != 0);
        cmd_addr   = c_AW'($urandom);
        cmd_data   = c_DW'($urandom);
        rsp_ready  = ($urandom_range(0, 3) != 0);
        tgt_ready  = ($urandom_range(0, 9) < 3);
        man_normal = c_DW'($urandom);
        man_ext    = 48'({$urandom, $urandom});
        man_full   = 24'($urandom);
        man_status = 4'($urandom);
        #1;
        check_val("rnd_busy", busy, outstanding != 0);
        check_val("rnd_rsp_valid", rsp_valid, exp_q.size() != 0);
        if (rsp_valid && exp_q.size() != 0) begin
            r = exp_q[0];
            check_val("rnd_rsp_data", rsp_data, r.d);
            check_val("rnd_rsp_ext", rsp_ext, r.e);
            check_val("rnd_rsp_faddr", rsp_full_addr, r.fa);
            check_val("rnd_rsp_status", rsp_status, r.st);
            check_val("rnd_rsp_timeout", rsp_timeout, r.to);
            if (rsp_ready) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
        end
        if (tgt_enable) begin
            if (en_cnt == 0) begin
                check_val("rnd_issue_has_cmd", cmd_q.size() != 0, 1'b1);
                if (cmd_q.size() != 0) cur = cmd_q.pop_front();
            end
            check_val("rnd_tgt_addr", tgt_addr, cur.addr);
            check_val("rnd_tgt_data", tgt_data, cur.data);
            en_cnt++;
            if (tgt_ready) begin
                exp_q.push_back({man_normal, man_ext, man_full, man_status, 1'b0});
                en_cnt = 0;
            end else if (en_cnt == c_TO) begin
                exp_q.push_back({16'h0, 48'h0, 24'h0, 4'hF, 1'b1});
                en_cnt = 0;
            end
        end
        if (cmd_valid && cmd_ready) begin
            cmd_q.push_back({cmd_addr, cmd_data});
            outstanding++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   acc;
        int   got;
        int   stray;
        bit   took;
        logic [c_AW-1:0] ea;
        logic [c_DW-1:0] ed;

        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; tgt_ready = 1'b0; echo = 1'b0;
        man_normal = '0; man_ext = '0; man_full = '0; man_status = '0;
        repeat (3) tick();

        // Reset state
        check_val("rst_cmd_ready", cmd_ready, 1'b0);
        check_val("rst_tgt_enable", tgt_enable, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rsp_data", rsp_data, 16'h0);
        check_val("rst_rsp_status", rsp_status, 4'h0);
        check_val("rst_tgt_addr", tgt_addr, 12'h0);
        reset = 1'b0;
        #1;
        check_val("rst_release_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        check_val("rst_release_cmd_ready_high", cmd_ready, 1'b1);

        // Single command with ready tied high
        tgt_ready = 1'b1;
        man_normal = 16'h1234; man_ext = 48'hAAAA_BBBB_CCCC; man_full = 24'h00_0123; man_status = 4'h1;
        cmd_valid = 1'b1; cmd_addr = 12'h123; cmd_data = 16'hBEEF;
        tick();
        cmd_valid = 1'b0;
        check_val("single_en_n", tgt_enable, 1'b0);
        tick();
        check_val("single_en_n1", tgt_enable, 1'b1);
        check_val("single_tgt_addr", tgt_addr, 12'h123);
        check_val("single_tgt_data", tgt_data, 16'hBEEF);
        tick();
        check_val("single_rsp_valid", rsp_valid, 1'b1);
        check_val("single_rsp_data", rsp_data, 16'h1234);
        check_val("single_rsp_ext", rsp_ext, 48'hAAAA_BBBB_CCCC);
        check_val("single_rsp_faddr", rsp_full_addr, 24'h00_0123);
        check_val("single_rsp_status", rsp_status, 4'h1);
        check_val("single_rsp_timeout", rsp_timeout, 1'b0);
        man_normal = 16'hFFFF;
        tick();
        check_val("single_hold_valid", rsp_valid, 1'b1);
        check_val("single_hold_data", rsp_data, 16'h1234);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("single_accepted", rsp_valid, 1'b0);
        check_val("single_idle_busy", busy, 1'b0);

        // Wait states: ready low for five enable cycles, high on the sixth
        tgt_ready = 1'b0;
        man_normal = 16'h0BAD; man_ext = 48'h1111_2222_3333; man_full = 24'h45_6456; man_status = 4'h3;
        cmd_valid = 1'b1; cmd_addr = 12'h456; cmd_data = 16'h7777;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) begin
            check_val($sformatf("wait_en_%0d", i), tgt_enable, 1'b1);
            check_val($sformatf("wait_addr_%0d", i), tgt_addr, 12'h456);
            check_val($sformatf("wait_data_%0d", i), tgt_data, 16'h7777);
            if (i == 6) tgt_ready = 1'b1;
            tick();
        end
        tgt_ready = 1'b0;
        check_val("wait_rsp_valid", rsp_valid, 1'b1);
        check_val("wait_en_dropped", tgt_enable, 1'b0);
        check_val("wait_rsp_data", rsp_data, 16'h0BAD);
        check_val("wait_rsp_timeout", rsp_timeout, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout followed by a normally completing queued command
        man_normal = 16'hDEAD; man_ext = 48'hFFFF_FFFF_FFFF; man_full = 24'hFF_FFFF; man_status = 4'h7;
        cmd_valid = 1'b1; cmd_addr = 12'h321; cmd_data = 16'h1111;
        tick();
        cmd_addr = 12'h654; cmd_data = 16'h2222;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < c_TO; i++) begin
            check_val($sformatf("to_en_%0d", i), tgt_enable, 1'b1);
            check_val($sformatf("to_no_rsp_%0d", i), rsp_valid, 1'b0);
            tick();
        end
        check_val("to_rsp_valid", rsp_valid, 1'b1);
        check_val("to_rsp_timeout", rsp_timeout, 1'b1);
        check_val("to_rsp_status", rsp_status, 4'hF);
        check_val("to_rsp_data", rsp_data, 16'h0);
        check_val("to_rsp_ext", rsp_ext, 48'h0);
        check_val("to_rsp_faddr", rsp_full_addr, 24'h0);
        check_val("to_en_dropped", tgt_enable, 1'b0);
        tgt_ready = 1'b1;
        man_normal = 16'hC0DE; man_status = 4'h2;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("to_accepted", rsp_valid, 1'b0);
        tick();
        check_val("to_next_en", tgt_enable, 1'b1);
        check_val("to_next_addr", tgt_addr, 12'h654);
        tick();
        check_val("to_next_valid", rsp_valid, 1'b1);
        check_val("to_next_timeout", rsp_timeout, 1'b0);
        check_val("to_next_data", rsp_data, 16'hC0DE);
        check_val("to_next_status", rsp_status, 4'h2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // FIFO full with response backpressure
        echo = 1'b1; tgt_ready = 1'b1; rsp_ready = 1'b0;
        acc = 0;
        cmd_valid = 1'b1; cmd_addr = 12'h100; cmd_data = 16'h3000;
        for (int c = 0; c < 12; c++) begin
            took = cmd_valid && cmd_ready;
            tick();
            if (took) begin
                acc++;
                if (acc < 6) begin
                    cmd_addr = c_AW'(12'h100 + acc);
                    cmd_data = c_DW'(16'h3000 + acc);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check_val("full_accepted", acc, 5);
        check_val("full_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid && rsp_ready) begin
                ea = c_AW'(12'h100 + got);
                ed = c_DW'(16'h3000 + got);
                check_val($sformatf("full_rsp_faddr_%0d", got), rsp_full_addr, {ea, ~ea});
                check_val($sformatf("full_rsp_data_%0d", got), rsp_data, ed ^ 16'h5A5A);
                got++;
            end
            tick();
        end
        check_val("full_rsp_count", got, 5);
        check_val("full_drained_busy", busy, 1'b0);
        rsp_ready = 1'b0; echo = 1'b0;

        // Reset while a transaction is in ISSUE with more commands queued
        tgt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = c_AW'(12'h700 + i); cmd_data = c_DW'(16'h9000 + i);
            tick();
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && !tgt_enable; c++) tick();
        check_val("rst_mid_pre_en", tgt_enable, 1'b1);
        reset = 1'b1;
        tick();
        check_val("rst_mid_en", tgt_enable, 1'b0);
        check_val("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check_val("rst_mid_cmd_ready", cmd_ready, 1'b1);
        tgt_ready = 1'b1; rsp_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid || tgt_enable) stray++;
            tick();
        end
        check_val("rst_mid_stray", stray, 0);
        check_val("rst_mid_idle_busy", busy, 1'b0);

        // Randomized traffic against the queue model
        cmd_q.delete();
        exp_q.delete();
        en_cnt = 0;
        outstanding = 0;
        repeat (3000) rand_cycle(1'b1);
        for (int i = 0; i < 500 && outstanding != 0; i++) rand_cycle(1'b0);
        check_val("rnd_drained", outstanding, 0);
        check_val("rnd_cmd_q_empty", cmd_q.size(), 0);
        check_val("rnd_final_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
